// File: rtl/dsp_cic_int.sv
// N-stage CIC interpolator: low-rate comb section fed through a din_rdy strobe,
// zero stuffing, then a full-rate integrator chain with full and reduced-width outputs.
module dsp_cic_int #(
   parameter int R          = 100,
   parameter int M          = 1,
   parameter int N          = 3,
   parameter int BIN        = 10,
   parameter int COUT       = 16,
   parameter int BOUT       = BIN + $clog2(((R * M) ** N) / R),
   parameter     CUT_METHOD = "ROUND"
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic signed [BIN-1:0]  din,
   input  logic                   din_vld,
   output logic                   din_rdy,
   output logic signed [BOUT-1:0] dout,
   output logic signed [COUT-1:0] dout_cut,
   output logic                   dout_vld,
   output logic                   err_underrun
);

   localparam int CW = (R > 1) ? $clog2(R) : 1;
   localparam int S  = BOUT - COUT;

   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   din_rdy_q, din_rdy_d;
   logic                   stuff_q, stuff_d;
   logic                   err_q, err_d;
   logic [N:0]             vld_sh_q, vld_sh_d;
   logic signed [BOUT-1:0] dly_q [N][M];
   logic signed [BOUT-1:0] dly_d [N][M];
   logic signed [BOUT-1:0] c_out_q, c_out_d;
   logic signed [BOUT-1:0] integ_q [N];
   logic signed [BOUT-1:0] integ_d [N];
   logic signed [COUT-1:0] cut_q, cut_d;
   logic signed [BOUT-1:0] c_acc;
   logic signed [BOUT-1:0] u;

   always_comb begin
      cnt_d     = (cnt_q == CW'(R - 1)) ? '0 : cnt_q + 1'b1;
      din_rdy_d = (cnt_q == CW'(R - 1));
      stuff_d   = din_rdy_q;
      err_d     = err_q | (din_rdy_q & ~din_vld);

      // vld_sh[k] is a sticky flag that the first sample has reached integrator depth k
      vld_sh_d[0] = vld_sh_q[0] | din_rdy_q;
      for (int k = 1; k <= N; k++) begin
         vld_sh_d[k] = vld_sh_q[k] | vld_sh_q[k-1];
      end

      // Comb chain evaluated combinationally; delay lines only move on an accept
      dly_d   = dly_q;
      c_out_d = c_out_q;
      c_acc   = din_vld ? BOUT'(din) : '0;
      for (int s = 0; s < N; s++) begin
         if (din_rdy_q) begin
            dly_d[s][0] = c_acc;
            for (int m = 1; m < M; m++) begin
               dly_d[s][m] = dly_q[s][m-1];
            end
         end
         c_acc = c_acc - dly_q[s][M-1];
      end
      if (din_rdy_q) begin
         c_out_d = c_acc;
      end

      u          = stuff_q ? c_out_q : '0;
      integ_d[0] = integ_q[0] + u;
      for (int k = 1; k < N; k++) begin
         integ_d[k] = integ_q[k] + integ_q[k-1];
      end
   end

   // dout_cut is derived from the next dout so both registers stay aligned
   generate
      if (S <= 0) begin : g_ext
         always_comb cut_d = COUT'(integ_d[N-1]);
      end else if (CUT_METHOD == "CUT") begin : g_cut
         always_comb cut_d = integ_d[N-1][BOUT-1:S];
      end else begin : g_round
         logic signed [BOUT:0] rsum;
         logic signed [COUT:0] rsh;
         always_comb begin
            rsum = {integ_d[N-1][BOUT-1], integ_d[N-1]} + (BOUT + 1)'(2 ** (S - 1));
            rsh  = rsum[BOUT:S];
            if (rsh[COUT] != rsh[COUT-1]) begin
               cut_d = rsh[COUT] ? {1'b1, {(COUT - 1){1'b0}}} : {1'b0, {(COUT - 1){1'b1}}};
            end else begin
               cut_d = rsh[COUT-1:0];
            end
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q     <= '0;
         din_rdy_q <= 1'b0;
         stuff_q   <= 1'b0;
         err_q     <= 1'b0;
         vld_sh_q  <= '0;
         c_out_q   <= '0;
         cut_q     <= '0;
         for (int s = 0; s < N; s++) begin
            integ_q[s] <= '0;
            for (int m = 0; m < M; m++) begin
               dly_q[s][m] <= '0;
            end
         end
      end else begin
         cnt_q     <= cnt_d;
         din_rdy_q <= din_rdy_d;
         stuff_q   <= stuff_d;
         err_q     <= err_d;
         vld_sh_q  <= vld_sh_d;
         c_out_q   <= c_out_d;
         cut_q     <= cut_d;
         dly_q     <= dly_d;
         integ_q   <= integ_d;
      end
   end

   assign din_rdy      = din_rdy_q;
   assign dout         = integ_q[N-1];
   assign dout_cut     = cut_q;
   assign dout_vld     = vld_sh_q[N];
   assign err_underrun = err_q;

endmodule

// File: tb/tb_dsp_cic_int.sv
// Bench for dsp_cic_int: a boxcar-convolution model of the interpolator checked
// every cycle against a small-ratio instance and two default-ratio instances.
module tb_dsp_cic_int;

   localparam int RA = 4,   NA = 3, BOUTA = 14, COUTA = 16;
   localparam int RD = 100, ND = 3, BOUTD = 24, COUTD = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic signed [9:0]  din_a, din_d;
   logic               vld_a, vld_d;
   logic               rdy_a, rdy_r, rdy_c;
   logic signed [BOUTA-1:0] dout_a;
   logic signed [BOUTD-1:0] dout_r, dout_c;
   logic signed [COUTA-1:0] cut_a;
   logic signed [COUTD-1:0] cut_r, cut_c;
   logic               ovld_a, ovld_r, ovld_c;
   logic               err_a, err_r, err_c;

   dsp_cic_int #(.R(RA), .M(1), .N(NA), .BIN(10), .COUT(COUTA), .CUT_METHOD("ROUND")) dut_a (
      .clk(clk), .rst_n(rst_n), .din(din_a), .din_vld(vld_a), .din_rdy(rdy_a),
      .dout(dout_a), .dout_cut(cut_a), .dout_vld(ovld_a), .err_underrun(err_a));

   dsp_cic_int #(.CUT_METHOD("ROUND")) dut_r (
      .clk(clk), .rst_n(rst_n), .din(din_d), .din_vld(vld_d), .din_rdy(rdy_r),
      .dout(dout_r), .dout_cut(cut_r), .dout_vld(ovld_r), .err_underrun(err_r));

   dsp_cic_int #(.CUT_METHOD("CUT")) dut_c (
      .clk(clk), .rst_n(rst_n), .din(din_d), .din_vld(vld_d), .din_rdy(rdy_c),
      .dout(dout_c), .dout_cut(cut_c), .dout_vld(ovld_c), .err_underrun(err_c));

   typedef struct {
      int     a;
      longint x;
   } acc_t;

   acc_t   qa[$];
   acc_t   qd[$];
   longint ha[$];
   longint hd[$];
   int     cyc = 0;
   int     run = 0;
   int     checks = 0;
   int     errors = 0;
   int     err_from_a = -1;
   int     err_from_d = -1;
   int     pulses = 0;
   int     first_pulse = -1;
   int     imp_tbl [11] = '{1, 3, 6, 10, 12, 12, 10, 6, 3, 1, 0};

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s run=%0d cyc=%0d got %0d expected %0d", nm, run, cyc, act, exp);
      end
   endtask

   // Impulse response of the whole interpolator: N-fold convolution of a length-L boxcar
   task automatic build_h(input int L, input int n, output longint h[$]);
      longint cur[$];
      longint nxt[$];
      cur = {64'sd1};
      for (int p = 0; p < n; p++) begin
         nxt = {};
         for (int i = 0; i < cur.size() + L - 1; i++) nxt.push_back(0);
         for (int i = 0; i < cur.size(); i++)
            for (int j = 0; j < L; j++) nxt[i+j] = nxt[i+j] + cur[i];
         cur = nxt;
      end
      h = cur;
   endtask

   function automatic longint wrapw(input longint v, input int w);
      longint m;
      m = v & ((64'sd1 <<< w) - 1);
      if (m >= (64'sd1 <<< (w - 1))) m = m - (64'sd1 <<< w);
      return m;
   endfunction

   function automatic longint cut_m(input longint v, input int bout, input int cout, input bit rnd);
      int     s;
      longint t, mx, mn;
      s = bout - cout;
      if (s <= 0) return v;
      if (!rnd) return v >>> s;
      t  = (v + (64'sd1 <<< (s - 1))) >>> s;
      mx = (64'sd1 <<< (cout - 1)) - 1;
      mn = -(64'sd1 <<< (cout - 1));
      if (t > mx) t = mx;
      if (t < mn) t = mn;
      return t;
   endfunction

   function automatic longint model_y(input acc_t q[$], input longint h[$], input int t,
                                      input int n, input int w);
      longint s;
      int     idx;
      s = 0;
      for (int i = 0; i < q.size(); i++) begin
         idx = t - (n + 1) - q[i].a;
         if (idx >= 0 && idx < h.size()) s = s + q[i].x * h[idx];
      end
      return wrapw(s, w);
   endfunction

   task automatic check_zero();
      chk("rst_dout_a", dout_a, 0);  chk("rst_cut_a", cut_a, 0);
      chk("rst_rdy_a", rdy_a, 0);    chk("rst_vld_a", ovld_a, 0);  chk("rst_err_a", err_a, 0);
      chk("rst_dout_r", dout_r, 0);  chk("rst_cut_r", cut_r, 0);
      chk("rst_rdy_r", rdy_r, 0);    chk("rst_vld_r", ovld_r, 0);  chk("rst_err_r", err_r, 0);
      chk("rst_dout_c", dout_c, 0);  chk("rst_cut_c", cut_c, 0);
      chk("rst_rdy_c", rdy_c, 0);    chk("rst_vld_c", ovld_c, 0);  chk("rst_err_c", err_c, 0);
   endtask

   task automatic drive();
      din_a = (run == 0 && cyc <= RA) ? 10'sd1 : 10'sd0;
      vld_a = 1'b1;
      vld_d = !(run == 0 && cyc > 1200 && cyc <= 1300);
      din_d = (run == 0 && cyc >= 2400) ? -10'sd512 : 10'sd511;
   endtask

   // Single compare process: model state advances and every output is checked each cycle
   always @(negedge clk) begin
      longint ya, yd;
      acc_t   e;
      if (!rst_n) begin
         check_zero();
      end else begin
         if (cyc > 0 && cyc % RA == 0) begin
            e.a = cyc; e.x = vld_a ? longint'(din_a) : 0;
            qa.push_back(e);
            if (!vld_a && err_from_a < 0) err_from_a = cyc + 1;
         end
         if (cyc > 0 && cyc % RD == 0) begin
            e.a = cyc; e.x = vld_d ? longint'(din_d) : 0;
            qd.push_back(e);
            if (!vld_d && err_from_d < 0) err_from_d = cyc + 1;
         end
         while (qa.size() > 0 && cyc - (NA + 1) - qa[0].a >= ha.size()) void'(qa.pop_front());
         while (qd.size() > 0 && cyc - (ND + 1) - qd[0].a >= hd.size()) void'(qd.pop_front());
         ya = model_y(qa, ha, cyc, NA, BOUTA);
         yd = model_y(qd, hd, cyc, ND, BOUTD);

         chk("dout_a", dout_a, ya);
         chk("cut_a", cut_a, cut_m(ya, BOUTA, COUTA, 1'b1));
         chk("rdy_a", rdy_a, (cyc > 0 && cyc % RA == 0));
         chk("vld_a", ovld_a, (cyc >= RA + NA + 1));
         chk("err_a", err_a, (err_from_a >= 0 && cyc >= err_from_a));

         chk("dout_r", dout_r, yd);
         chk("cut_r", cut_r, cut_m(yd, BOUTD, COUTD, 1'b1));
         chk("dout_c", dout_c, yd);
         chk("cut_c", cut_c, cut_m(yd, BOUTD, COUTD, 1'b0));
         chk("rdy_r", rdy_r, (cyc > 0 && cyc % RD == 0));
         chk("vld_r", ovld_r, (cyc >= RD + ND + 1));
         chk("err_r", err_r, (err_from_d >= 0 && cyc >= err_from_d));
         chk("err_c", err_c, (err_from_d >= 0 && cyc >= err_from_d));

         if (run == 0 && cyc >= 8 && cyc <= 18) chk("imp_lit", dout_a, imp_tbl[cyc-8]);
         if (run == 0 && cyc >= 1 && cyc <= 1000 && rdy_r) begin
            pulses++;
            if (first_pulse < 0) first_pulse = cyc;
         end
         if (run == 0 && cyc == 1000) begin
            chk("strobe_count", pulses, 10);
            chk("strobe_first", first_pulse, 100);
         end
         if (cyc == 1199) begin
            chk("dc_lit", dout_r, 5110000);
            chk("dc_round_lit", cut_r, 19961);
            chk("dc_cut_lit", cut_c, 19960);
            if (run == 1) chk("err_after_rst", err_r, 0);
         end
         if (run == 0 && cyc == 2399) begin
            chk("recover_lit", dout_r, 5110000);
            chk("err_sticky_lit", err_r, 1);
         end
         if (run == 0 && cyc == 3599) begin
            chk("neg_dc_lit", dout_r, -5120000);
            chk("neg_round_lit", cut_r, -20000);
            chk("neg_cut_lit", cut_c, -20000);
         end
      end
   end

   initial begin
      build_h(RA, NA, ha);
      build_h(RD, ND, hd);
      din_a = '0; din_d = '0; vld_a = 1'b0; vld_d = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b1;
      cyc = 0;
      run = 0;
      drive();
      while (cyc < 3600) begin
         @(posedge clk);
         #1;
         cyc++;
         drive();
      end
      #1;
      rst_n = 1'b0;
      qa.delete(); qd.delete();
      err_from_a = -1; err_from_d = -1;
      #1;
      check_zero();
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
      cyc = 0;
      run = 1;
      drive();
      while (cyc < 1300) begin
         @(posedge clk);
         #1;
         cyc++;
         drive();
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dsp_cic_int.md
Name: dsp_cic_int

Overview:
- N-stage CIC interpolator: the transmit-side counterpart of the CIC decimator.
- Pulls one BIN-bit sample every R clocks via a ready strobe.
- Produces one BOUT-bit sample every clock, plus a rounded or truncated COUT-bit copy.
- Sits between a low-rate sample source (baseband generator, sine ROM) and high-rate DAC/mixer logic on the same clock.

Parameters:
R, 100, interpolation ratio (>=2)
M, 1, differential delay of each comb stage (1 or 2)
N, 3, number of comb and integrator stages (1..6)
BIN, 10, input width, signed two's complement
COUT, 16, width of dout_cut
BOUT, BIN+$clog2(((R*M)**N)/R), full-precision output width (24 at defaults)
CUT_METHOD, "ROUND", "ROUND" = round half up with saturation; "CUT" = truncate

Ports:
clk  input  1  sample clock (high rate fs)
rst_n  input  1  asynchronous active-low reset
din  input  BIN  signed input sample; sampled when din_rdy=1
din_vld  input  1  source has a sample present; sampled when din_rdy=1
din_rdy  output  1  one-cycle request strobe, once every R clocks
dout  output  BOUT  signed full-precision output
dout_cut  output  COUT  signed reduced-width output
dout_vld  output  1  output valid; high every clock once primed
err_underrun  output  1  sticky flag: a request found din_vld=0

Behaviour:
- Reset (async assert, sync release):
  - Phase counter, comb delay lines, comb output register, integrators and dout go to 0.
  - din_rdy, dout_vld and err_underrun go to 0.
- Phase counter:
  - Counts 0..R-1 every clock and wraps to 0.
  - din_rdy is registered: high for exactly one cycle when the counter value is R-1.
  - First din_rdy pulse is in cycle R after reset release; then strictly periodic, period R. There is no back-pressure.
- Accept: a cycle with din_rdy=1.
  - If din_vld=1, x=din.
  - If din_vld=0, x=0 and err_underrun sets. err_underrun stays set until reset.
- Comb section (low rate, enabled only on accept):
  - Combinational chain c0=x, ck=c(k-1)-c(k-1)[delayed M accepts], computed in BOUT bits with sign extension.
  - Delay registers shift on accept only.
  - Comb result cN is registered into c_out on the accept edge.
- Zero stuffing: integrator input u=c_out in the cycle after an accept, otherwise u=0.
- Integrator section (every clock):
  - I1<=I1+u, Ik<=Ik+I(k-1), all in BOUT bits.
  - Wrap-around (modular) arithmetic is required and intentional; no saturation inside the filter.
- dout = I_N register.
- Latency: an accept in cycle 0 first affects dout in cycle N+1.
- dout_vld:
  - Rises in cycle N+1 after the first accept following reset.
  - Then stays high every clock until reset.
- DC gain = (R*M)^N / R.
- dout_cut:
  - Registered alongside dout (same cycle alignment as dout). S = BOUT-COUT.
  - If S<=0: sign-extend dout.
  - "CUT": dout[BOUT-1:S].
  - "ROUND": (dout + 2^(S-1)) >> S, saturated to [-2^(COUT-1), 2^(COUT-1)-1] when the add overflows.
- Reset mid-operation: all state cleared immediately, no partial outputs. The din_rdy schedule restarts as after power-up.
- Simultaneous events: an accept and a non-zero u in the same cycle are legal (possible since R>=2); both update normally.

Test Plan:
1. Impulse, R=4 M=1 N=3: din=1 on the first accept, then 0 -> dout from cycle N+1 = 1,3,6,10,12,12,10,6,3,1 then 0 forever; dout_vld high from cycle 4 after that accept.
2. DC at defaults: din=511 constant with din_vld=1 -> dout settles to 5,110,000; dout_cut ROUND = 19961; CUT build = 19960.
3. Negative DC at defaults: din=-512 -> dout settles to -5,120,000; dout_cut ROUND = -20000.
4. Strobe timing: count clocks over 10 request periods -> din_rdy pulses exactly every 100 clocks, each 1 cycle wide, first pulse in cycle 100 after reset release.
5. Underrun: din_vld=0 on one request during DC=511 -> that sample treated as 0 (transient dip, recovers to 5,110,000); err_underrun=1 and stays set until rst_n pulse.
6. Reset mid-stream: assert rst_n=0 during DC run -> dout, dout_cut, dout_vld, din_rdy all 0 asynchronously; after release, behaviour identical to scenario 2 from cycle 0.
